uart_tx_serializer: RTL

//   UART transmit serializer; sits directly downstream of the baud tick generator.
//   - Drives the generator's enable input.
//   - Consumes its per-bit tick to shift one byte onto tx: start, LSB-first data, optional parity, stop.
//   - Provides a start/busy/done handshake to the host logic.

---
 rtl/uart_tx_serializer_if.sv | 24 ++
 rtl/uart_tx_serializer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// Host-side start/busy/done handshake for the UART transmit serializer.
// The host drives tx_start/tx_data (master); the serializer answers (slave).
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_tx_serializer_if.slave     host,
    input  logic                    baud_tick,
    output logic                    baud_en,
    output logic                    tx
);
    localparam int CW = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_serializer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Register the frame state and all line/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state and next-output decode; each baud_tick ends the current bit.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        en_d       = en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (host.tx_start) begin
                    state_d    = START;
                    shreg_d    = host.tx_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    en_d       = 1'b1;
                    busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d      = (PARITY_ODD != 0) ? ~^host.tx_data
                                                   : ^host.tx_data;
`endif
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
`endif
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx           = tx_q;
    assign baud_en      = en_q;
    assign host.tx_busy = busy_q;
    assign host.tx_done = done_q;
endmodule
